ps2_mouse_tracker: RTL and testbench
====================================

// Module: ps2_mouse_tracker
// PURPOSE
// - Upstream of the tic-tac-toe game controller. Receives PS/2 mouse stream packets
//   (receive-only) and produces a clamped screen cursor position plus a left-click pulse.
// - The controller consumes these as mouseX / mouseY / mouseBotton to pick a board cell.
// - Stream-mode enable (0xF4) is issued by a separate block.
// PARAMETERS
// - H_RES        640     horizontal screen size; mouse_x range 0..H_RES-1
// - V_RES        480     vertical screen size; mouse_y range 0..V_RES-1
// - X_INIT       320     mouse_x value at reset
// - Y_INIT       240     mouse_y value at reset
// - FILT_LEN     8       ps2_clk glitch filter: consecutive equal samples required
// - TIMEOUT_CYC  50000   idle clk cycles mid-byte or mid-packet before resync (2 ms at 25 MHz)
// PORTS
// - clk          in   1   system clock (25 MHz pixel clock)
// - rst_n        in   1   asynchronous active-low reset
// - ps2_clk      in   1   raw PS/2 clock from the connector (asynchronous)
// - ps2_data     in   1   raw PS/2 data from the connector (asynchronous)
// - mouse_x      out  10  cursor X, 0 = left edge
// - mouse_y      out  10  cursor Y, 0 = top edge
// - btn_left     out  1   current left-button level from the last good packet
// - click        out  1   one-cycle pulse on a left-button 0->1 transition
// - pkt_err      out  1   one-cycle pulse when a byte or packet is discarded
// BEHAVIOUR
// - Reset values: mouse_x=X_INIT, mouse_y=Y_INIT; btn_left, click, pkt_err = 0.
//   Byte index = 0; receiver idle.
// - Input conditioning:
//   - ps2_clk and ps2_data each pass through a 2-flop synchroniser.
//   - ps2_clk then passes a FILT_LEN shift filter.
//   - Falling edge of the filtered clock = bit strobe.
// - Byte receiver states, advancing one bit per strobe:
//   - IDLE -> DATA on start bit 0; a start bit of 1 is ignored.
//   - DATA: 8 data bits, LSB first -> PARITY -> STOP.
//   - Byte is good iff parity makes the 9-bit count of ones odd AND stop bit = 1.
//   - A good byte raises byte_valid for 1 cycle on the cycle after the stop strobe.
//   - A bad byte pulses pkt_err and returns to IDLE.
// - Packet assembly:
//   - Byte index 0 accepted only if bit3 = 1; otherwise pkt_err pulses and the index stays 0.
//   - Byte 1 = dx, byte 2 = dy.
//   - Byte 0 fields: bit0 = left, bit4 = X sign, bit5 = Y sign, bit6 = X overflow,
//     bit7 = Y overflow.
// - Position update, on the cycle after the byte-2 byte_valid (2-cycle latency from the stop strobe):
//   - Delta = 9-bit two's complement {sign, byte}.
//   - If an axis's overflow bit is set, that axis's delta is forced to 0.
//   - Next X = mouse_x + dx, next Y = mouse_y - dy (PS/2 +Y is up).
//   - Sums use 12-bit signed arithmetic, then clamp: <0 -> 0, >RES-1 -> RES-1.
//   - In the same cycle: btn_left <= left; click = left & ~btn_left(old).
// - Timeout:
//   - The counter clears on every bit strobe.
//   - While the receiver is not IDLE, or the byte index is not 0, reaching TIMEOUT_CYC
//     sends the receiver to IDLE, sets the index to 0 and pulses pkt_err.
//   - A partial packet never updates any output.
// - Simultaneous events:
//   - A timeout and a strobe in the same cycle: the strobe wins and the counter clears.
//   - A bad byte at index 1 or 2 also resets the index to 0.
// - Reset asserted mid-packet: all state returns to reset values immediately;
//   no update is issued for the partial packet.
// STRUCTURE
// - Shared package (ps2_pkg):
//   - receiver state encoding (IDLE/DATA/PARITY/STOP);
//   - byte-0 bit-position constants (BTN_L=0, ALWAYS1=3, XSIGN=4, YSIGN=5, XOVF=6, YOVF=7);
//   - screen constants H_RES/V_RES, shared with the VGA and game controller blocks.
// - One sub-module, ps2_rx:
//   - contains the synchronisers, filter, edge detect, byte FSM and parity/stop check;
//   - outputs rx_byte[7:0], byte_valid, byte_err, busy.
// - The top level holds packet assembly, the timeout counter and the clamp/update logic.
// TESTING
// - Reset: rst_n low, then high -> mouse_x=320, mouse_y=240, click=0, pkt_err=0.
// - Packet 08,0A,05 -> mouse_x=330, mouse_y=235, 2 cycles after the 3rd stop; click=0.
// - Packet 39,F0,E0 (dx=-16, dy=-32) sent 25 times from reset
//   -> mouse_x clamps to 0, mouse_y clamps to 479.
// - Packet 09,00,00 then 09,00,00 -> click pulses once (exactly 1 cycle);
//   btn_left=1; no second click.
// - Byte with bad parity at index 1 -> pkt_err pulse, position unchanged;
//   next 08,01,00 -> mouse_x+1.
// - Byte 08 then 3 ms idle -> pkt_err pulse at TIMEOUT_CYC;
//   following 08,02,00 -> mouse_x+2 (resynced).
// - Packet 48,FF,00 (X overflow set) -> mouse_x unchanged.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 mouse definitions: receiver states, packet header bit positions,
// screen geometry shared with the VGA and game-controller blocks.
package ps2_pkg;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  localparam int BTN_L   = 0;
  localparam int ALWAYS1 = 3;
  localparam int XSIGN   = 4;
  localparam int YSIGN   = 5;
  localparam int XOVF    = 6;
  localparam int YOVF    = 7;

  localparam int H_RES = 640;
  localparam int V_RES = 480;

  // Header fields kept from byte 0 until the packet completes.
  typedef struct packed {
    logic yovf;
    logic xovf;
    logic ysign;
    logic xsign;
    logic left;
  } hdr_t;

  // v is a 12-bit two's complement sum; saturate into 0..max_v.
  function automatic logic [9:0] clamp_axis(input logic [11:0] v, input logic [9:0] max_v);
    if (v[11])
      return 10'd0;
    else if (v > {2'b00, max_v})
      return max_v;
    else
      return v[9:0];
  endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 byte receiver: synchronisers, clock glitch filter, falling-edge strobe,
// and the start/data/parity/stop framing FSM with odd-parity and stop checks.
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int FILT_LEN = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       abort,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       byte_err,
  output logic       busy,
  output logic       strobe
);

  logic [1:0]          clk_sync_reg, data_sync_reg;
  logic [FILT_LEN-1:0] filt_sr_reg;
  logic                filt_reg;
  rx_state_t           state_reg, state_next;
  logic [2:0]          cnt_reg, cnt_next;
  logic [7:0]          sr_reg, sr_next;
  logic                par_reg, par_next;
  logic                valid_reg, valid_next, err_reg, err_next;
  logic                bit_in;

  // The filtered clock only changes once FILT_LEN identical samples have been seen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync_reg  <= 2'b11;
      data_sync_reg <= 2'b11;
      filt_sr_reg   <= '1;
      filt_reg      <= 1'b1;
    end else begin
      clk_sync_reg  <= {clk_sync_reg[0], ps2_clk};
      data_sync_reg <= {data_sync_reg[0], ps2_data};
      filt_sr_reg   <= {filt_sr_reg[FILT_LEN-2:0], clk_sync_reg[1]};
      if (&filt_sr_reg)
        filt_reg <= 1'b1;
      else if (~|filt_sr_reg)
        filt_reg <= 1'b0;
    end
  end

  assign strobe = filt_reg & ~|filt_sr_reg;
  assign bit_in = data_sync_reg[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= RX_IDLE;
      cnt_reg   <= 3'd0;
      sr_reg    <= 8'd0;
      par_reg   <= 1'b0;
      valid_reg <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      sr_reg    <= sr_next;
      par_reg   <= par_next;
      valid_reg <= valid_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    sr_next    = sr_reg;
    par_next   = par_reg;
    valid_next = 1'b0;
    err_next   = 1'b0;
    if (abort) begin
      state_next = RX_IDLE;
    end else if (strobe) begin
      unique case (state_reg)
        RX_IDLE: begin
          if (!bit_in) begin
            state_next = RX_DATA;
            cnt_next   = 3'd0;
          end
        end
        RX_DATA: begin
          sr_next  = {bit_in, sr_reg[7:1]};
          cnt_next = cnt_reg + 3'd1;
          if (cnt_reg == 3'd7)
            state_next = RX_PARITY;
        end
        RX_PARITY: begin
          par_next   = bit_in;
          state_next = RX_STOP;
        end
        RX_STOP: begin
          state_next = RX_IDLE;
          if ((^{sr_reg, par_reg}) && bit_in)
            valid_next = 1'b1;
          else
            err_next = 1'b1;
        end
        default: state_next = RX_IDLE;
      endcase
    end
  end

  assign rx_byte    = sr_reg;
  assign byte_valid = valid_reg;
  assign byte_err   = err_reg;
  assign busy       = (state_reg != RX_IDLE);

endmodule

// File: rtl/ps2_mouse_tracker.sv
// PS/2 mouse stream decoder: assembles 3-byte packets, resyncs on idle timeout,
// and keeps a clamped cursor position plus left-button level and click pulse.
module ps2_mouse_tracker
  import ps2_pkg::*;
#(
  parameter int H_RES       = ps2_pkg::H_RES,
  parameter int V_RES       = ps2_pkg::V_RES,
  parameter int X_INIT      = 320,
  parameter int Y_INIT      = 240,
  parameter int FILT_LEN    = 8,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [9:0] mouse_x,
  output logic [9:0] mouse_y,
  output logic       btn_left,
  output logic       click,
  output logic       pkt_err
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] TO_MAX = CNT_W'(TIMEOUT_CYC - 1);

  logic [7:0]       rx_byte;
  logic             byte_valid, byte_err, busy, strobe, abort;
  logic [1:0]       idx_reg;
  hdr_t             hdr_reg;
  logic [7:0]       dx_reg;
  logic [CNT_W-1:0] to_cnt_reg;
  logic [9:0]       x_reg, y_reg;
  logic             btn_reg, click_reg, err_reg;
  logic [8:0]       dx9, dy9;
  logic [11:0]      sum_x, sum_y;

  ps2_rx #(.FILT_LEN(FILT_LEN)) u_rx (
    .clk        (clk),
    .rst_n      (rst_n),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .abort      (abort),
    .rx_byte    (rx_byte),
    .byte_valid (byte_valid),
    .byte_err   (byte_err),
    .busy       (busy),
    .strobe     (strobe)
  );

  // A strobe in the same cycle always beats the timeout.
  assign abort = (busy || idx_reg != 2'd0) && !strobe && (to_cnt_reg == TO_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      to_cnt_reg <= '0;
    else if (strobe || abort || !(busy || idx_reg != 2'd0))
      to_cnt_reg <= '0;
    else
      to_cnt_reg <= to_cnt_reg + 1'b1;
  end

  // dy arrives live on rx_byte in the cycle its byte_valid is high.
  always_comb begin
    dx9   = hdr_reg.xovf ? 9'd0 : {hdr_reg.xsign, dx_reg};
    dy9   = hdr_reg.yovf ? 9'd0 : {hdr_reg.ysign, rx_byte};
    sum_x = {2'b00, x_reg} + {{3{dx9[8]}}, dx9};
    sum_y = {2'b00, y_reg} - {{3{dy9[8]}}, dy9};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_reg   <= 2'd0;
      hdr_reg   <= '0;
      dx_reg    <= 8'd0;
      x_reg     <= 10'(X_INIT);
      y_reg     <= 10'(Y_INIT);
      btn_reg   <= 1'b0;
      click_reg <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      click_reg <= 1'b0;
      err_reg   <= 1'b0;
      if (abort || byte_err) begin
        idx_reg <= 2'd0;
        err_reg <= 1'b1;
      end else if (byte_valid) begin
        case (idx_reg)
          2'd0: begin
            if (rx_byte[ALWAYS1]) begin
              hdr_reg <= {rx_byte[YOVF], rx_byte[XOVF], rx_byte[YSIGN],
                          rx_byte[XSIGN], rx_byte[BTN_L]};
              idx_reg <= 2'd1;
            end else begin
              err_reg <= 1'b1;
            end
          end
          2'd1: begin
            dx_reg  <= rx_byte;
            idx_reg <= 2'd2;
          end
          default: begin
            x_reg     <= clamp_axis(sum_x, 10'(H_RES - 1));
            y_reg     <= clamp_axis(sum_y, 10'(V_RES - 1));
            btn_reg   <= hdr_reg.left;
            click_reg <= hdr_reg.left & ~btn_reg;
            idx_reg   <= 2'd0;
          end
        endcase
      end
    end
  end

  assign mouse_x  = x_reg;
  assign mouse_y  = y_reg;
  assign btn_left = btn_reg;
  assign click    = click_reg;
  assign pkt_err  = err_reg;

endmodule

// File: tb/tb_ps2_mouse_tracker.sv
// Scoreboard bench for ps2_mouse_tracker: the driver queues the expected output
// event for each stimulus, a monitor pops and compares whenever outputs move.
module tb_ps2_mouse_tracker;

  localparam int HALF = 16;
  localparam int TO   = 2000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [9:0] mouse_x, mouse_y;
  logic       btn_left, click, pkt_err;

  ps2_mouse_tracker #(.TIMEOUT_CYC(TO)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .mouse_x  (mouse_x),
    .mouse_y  (mouse_y),
    .btn_left (btn_left),
    .click    (click),
    .pkt_err  (pkt_err)
  );

  always #20 clk = ~clk;

  typedef struct {
    logic       err;
    logic [9:0] x;
    logic [9:0] y;
    logic       btn;
    logic       clk_pulse;
  } ev_t;

  ev_t  exp_q[$];
  ev_t  mon_ev;
  int   n_checks = 0;
  int   n_fail = 0;
  int   n_clicks = 0;
  int   mx = 320, my = 240;
  logic mbtn = 1'b0;
  logic [9:0] px, py;
  logic pb;
  int   c0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic bad);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ bad, b, 1'b0};
    for (int i = 0; i < 11; i++) begin
      ps2_data = f[i];
      tick(HALF);
      ps2_clk = 1'b0;
      tick(HALF);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    tick(2 * HALF);
  endtask

  task automatic push_err();
    exp_q.push_back('{1'b1, 10'(mx), 10'(my), mbtn, 1'b0});
  endtask

  function automatic int clampi(input int v, input int maxv);
    return (v < 0) ? 0 : ((v > maxv) ? maxv : v);
  endfunction

  // Model the packet's effect and queue an event only if some output will move.
  task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    int dx, dy, nx, ny;
    logic nclick;
    dx = b0[6] ? 0 : (b0[4] ? int'(b1) - 256 : int'(b1));
    dy = b0[7] ? 0 : (b0[5] ? int'(b2) - 256 : int'(b2));
    nx = clampi(mx + dx, 639);
    ny = clampi(my - dy, 479);
    nclick = b0[0] & ~mbtn;
    if (nx != mx || ny != my || b0[0] != mbtn || nclick)
      exp_q.push_back('{1'b0, 10'(nx), 10'(ny), b0[0], nclick});
    mx = nx;
    my = ny;
    mbtn = b0[0];
    send_byte(b0, 1'b0);
    send_byte(b1, 1'b0);
    send_byte(b2, 1'b0);
    tick(64);
  endtask

  task automatic do_reset();
    chk("queue_empty_before_reset", exp_q.size(), 0);
    exp_q.delete();
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    mx = 320;
    my = 240;
    mbtn = 1'b0;
    tick(4);
  endtask

  // Monitor: any output activity must match the next queued expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        px = mouse_x;
        py = mouse_y;
        pb = btn_left;
      end else begin
        if (click) n_clicks++;
        if (pkt_err || click || mouse_x != px || mouse_y != py || btn_left != pb) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_event: got x=%0d y=%0d btn=%0d click=%0d err=%0d, expected no event at %0t",
                     mouse_x, mouse_y, btn_left, click, pkt_err, $time);
          end else begin
            mon_ev = exp_q.pop_front();
            $display("event t=%0t x=%0d y=%0d btn=%0d click=%0d err=%0d",
                     $time, mouse_x, mouse_y, btn_left, click, pkt_err);
            chk("ev_err", pkt_err, mon_ev.err);
            chk("ev_x", mouse_x, mon_ev.x);
            chk("ev_y", mouse_y, mon_ev.y);
            chk("ev_btn", btn_left, mon_ev.btn);
            chk("ev_click", click, mon_ev.clk_pulse);
          end
        end
        px = mouse_x;
        py = mouse_y;
        pb = btn_left;
      end
    end
  end

  initial begin
    tick(3);
    rst_n = 1'b1;
    tick(4);
    @(negedge clk);
    chk("reset_x", mouse_x, 320);
    chk("reset_y", mouse_y, 240);
    chk("reset_btn", btn_left, 0);
    chk("reset_click", click, 0);
    chk("reset_err", pkt_err, 0);

    send_pkt(8'h08, 8'h0A, 8'h05);
    @(negedge clk);
    chk("move_x", mouse_x, 330);
    chk("move_y", mouse_y, 235);

    do_reset();
    for (int i = 0; i < 25; i++) send_pkt(8'h39, 8'hF0, 8'hE0);
    @(negedge clk);
    chk("clamp_x", mouse_x, 0);
    chk("clamp_y", mouse_y, 479);

    do_reset();
    c0 = n_clicks;
    send_pkt(8'h09, 8'h00, 8'h00);
    send_pkt(8'h09, 8'h00, 8'h00);
    @(negedge clk);
    chk("click_count", n_clicks - c0, 1);
    chk("btn_held", btn_left, 1);

    push_err();
    send_byte(8'h08, 1'b0);
    send_byte(8'h0A, 1'b1);
    tick(64);
    send_pkt(8'h08, 8'h01, 8'h00);
    @(negedge clk);
    chk("after_parity_x", mouse_x, 321);

    send_byte(8'h08, 1'b0);
    push_err();
    tick(3000);
    send_pkt(8'h08, 8'h02, 8'h00);
    @(negedge clk);
    chk("after_timeout_x", mouse_x, 323);

    push_err();
    send_byte(8'h00, 1'b0);
    tick(64);
    send_pkt(8'h08, 8'h00, 8'h03);
    @(negedge clk);
    chk("after_hdr_err_y", mouse_y, 237);

    send_pkt(8'h48, 8'hFF, 8'h00);
    send_pkt(8'h48, 8'hFF, 8'h05);
    @(negedge clk);
    chk("xovf_x", mouse_x, 323);
    chk("xovf_y", mouse_y, 232);

    send_byte(8'h08, 1'b0);
    send_byte(8'h0A, 1'b0);
    do_reset();
    send_pkt(8'h08, 8'h01, 8'h00);
    @(negedge clk);
    chk("midpkt_reset_x", mouse_x, 321);

    tick(100);
    chk("queue_empty_end", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
